// File: rtl/random_pool_arbiter_if.sv
// Consumer-side bundle for random_pool_arbiter: RNG byte handshake, client
// request/ack lines, delivered word and pool status.
interface random_pool_arbiter_if #(
  parameter int unsigned RATE       = 8,
  parameter int unsigned CLIENTS    = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned WORD_BYTES = 4
);
  localparam int unsigned FILL_W = $clog2(DEPTH) + 1;

  logic [RATE-1:0]            rng_data;
  logic                       rng_valid;
  logic                       rng_received;
  logic [CLIENTS-1:0]         req;
  logic [CLIENTS-1:0]         ack;
  logic [WORD_BYTES*RATE-1:0] word;
  logic [FILL_W-1:0]          fill;
  logic                       health_fail;

  modport master (
    output rng_data, rng_valid, req,
    input  rng_received, ack, word, fill, health_fail
  );

  modport slave (
    input  rng_data, rng_valid, req,
    output rng_received, ack, word, fill, health_fail
  );
endinterface

// File: rtl/random_pool_arbiter.sv
// Pools RNG chunks in a FIFO, health-tests the stream for repeats, and hands
// each assembled word to exactly one client in round-robin order.
module random_pool_arbiter #(
  parameter int unsigned RATE         = 8,
  parameter int unsigned CLIENTS      = 4,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned WORD_BYTES   = 4,
  parameter int unsigned REPEAT_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  random_pool_arbiter_if.slave bus
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;
  localparam int unsigned CLI_W  = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;
  localparam int unsigned CNT_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int unsigned RUN_W  = $clog2(REPEAT_LIMIT + 1);
  localparam int unsigned WORD_W = WORD_BYTES * RATE;

  typedef enum logic [1:0] {IDLE, COLLECT, DELIVER} state_e;

  state_e             state_q;
  logic [CLI_W-1:0]   sel_q;
  logic [CLI_W-1:0]   last_grant_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WORD_W-1:0]  acc_q;
  logic [WORD_W-1:0]  word_q;
  logic [CLIENTS-1:0] ack_q;

  logic [RATE-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [FILL_W-1:0]  fill_q;

  logic [RATE-1:0]    last_chunk_q;
  logic [RUN_W-1:0]   run_q;
  logic               health_fail_q;

  logic               rng_received;
  logic [RUN_W-1:0]   run_d;
  logic               trip;
  logic               push;
  logic               abort;
  logic               pop;
  logic [RATE-1:0]    pop_data;
  logic [WORD_W-1:0]  acc_d;
  logic               grant_found;
  logic [CLI_W-1:0]   grant_idx;

  // Handshake, repeat-run tracking and pop qualification
  always_comb begin
    rng_received = bus.rng_valid && (fill_q < FILL_W'(DEPTH)) && !health_fail_q && !rst;
    run_d        = (bus.rng_data == last_chunk_q) ? run_q + RUN_W'(1) : RUN_W'(1);
    trip         = rng_received && (run_d >= RUN_W'(REPEAT_LIMIT));
    push         = rng_received && !trip;
    abort        = health_fail_q || trip;
    pop          = (state_q == COLLECT) && !abort && bus.req[sel_q] && (fill_q != '0);
    pop_data     = mem_q[rd_ptr_q];
    acc_d        = acc_q;
    acc_d[32'(cnt_q) * RATE +: RATE] = pop_data;
  end

  // Round-robin search starting just after the last granted client
  always_comb begin
    logic [31:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 1; i <= CLIENTS; i++) begin
      cand = (32'(last_grant_q) + i) % CLIENTS;
      if (!grant_found && bus.req[CLI_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = CLI_W'(cand);
      end
    end
  end

  // Chunk pool; a health failure flushes it
  always_ff @(posedge clk) begin
    if (rst || health_fail_q) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= bus.rng_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      fill_q <= fill_q + FILL_W'(push) - FILL_W'(pop);
    end
  end

  // Repetition-count health test, sticky until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      last_chunk_q  <= '0;
      run_q         <= '0;
      health_fail_q <= 1'b0;
    end else if (rng_received) begin
      last_chunk_q <= bus.rng_data;
      run_q        <= run_d;
      if (trip) begin
        health_fail_q <= 1'b1;
      end
    end
  end

  // Arbiter FSM: ack and word register on the last pop so they show in DELIVER
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      last_grant_q <= CLI_W'(CLIENTS - 1);
      cnt_q        <= '0;
      acc_q        <= '0;
      word_q       <= '0;
      ack_q        <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (grant_found && !abort) begin
            sel_q   <= grant_idx;
            cnt_q   <= '0;
            acc_q   <= '0;
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          if (abort || !bus.req[sel_q]) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            state_q <= IDLE;
          end else if (pop) begin
            acc_q <= acc_d;
            if (cnt_q == CNT_W'(WORD_BYTES - 1)) begin
              word_q       <= acc_d;
              ack_q[sel_q] <= 1'b1;
              state_q      <= DELIVER;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        DELIVER: begin
          last_grant_q <= sel_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rng_received = rng_received;
  assign bus.ack          = ack_q;
  assign bus.word         = word_q;
  assign bus.fill         = fill_q;
  assign bus.health_fail  = health_fail_q;

endmodule
